// File: rtl/dec_round.sv
// AES-128 inverse-cipher round step: a two-stage elastic pipeline.
// Stage 1 does InvShiftRows+InvSubBytes; stage 2 does AddRoundKey and, for middle rounds, InvMixColumns.
module dec_round #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] rkey,
    input  logic [3:0]   addr,
    input  logic         din_valid,
    output logic         din_ready,
    input  logic [127:0] din,
    output logic         dout_valid,
    input  logic         dout_ready,
    output logic [127:0] dout,
    output logic         round_err
);

    typedef enum logic [1:0] {
        MODE_WHITEN = 2'd0,
        MODE_MID    = 2'd1,
        MODE_FINAL  = 2'd2,
        MODE_ERR    = 2'd3
    } mode_t;

    // Inverse S-box, one 16-byte row per line (row = high nibble of the input byte).
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul9(input logic [7:0] b);
        return xt(xt(xt(b))) ^ b;
    endfunction

    function automatic logic [7:0] mulb(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(b) ^ b;
    endfunction

    function automatic logic [7:0] muld(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
    endfunction

    function automatic logic [7:0] mule(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
    endfunction

    // Pipeline state
    logic         s1_valid_reg;
    logic [127:0] s1_data_reg;
    logic [127:0] s1_key_reg;
    mode_t        s1_mode_reg;
    logic         dout_valid_reg;
    logic [127:0] dout_reg;
    logic         round_err_reg;

    logic         s2_load;
    logic         accept;
    mode_t        s1_mode_next;
    logic [127:0] s1_data_next;
    logic [127:0] isr_isb;
    logic [127:0] keyed;
    logic [127:0] imc;
    logic [127:0] s2_data_next;

    assign s2_load   = s1_valid_reg && (!dout_valid_reg || dout_ready);
    assign din_ready = !s1_valid_reg || s2_load;
    assign accept    = din_valid && din_ready;

    // Byte gi lives at row gi%4, column gi/4; InvShiftRows pulls it from column (c - r) mod 4.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_isr_isb
            localparam int ROW = gi % 4;
            localparam int COL = gi / 4;
            localparam int SRC = 4 * ((COL - ROW + 4) % 4) + ROW;
            assign isr_isb[127-8*gi -: 8] = inv_sbox(din[127-8*SRC -: 8]);
        end
    endgenerate

    always_comb begin
        s1_mode_next = MODE_ERR;
        if (addr == 4'd0)
            s1_mode_next = MODE_WHITEN;
        else if (addr < 4'(NR))
            s1_mode_next = MODE_MID;
        else if (addr == 4'(NR))
            s1_mode_next = MODE_FINAL;
        s1_data_next = (s1_mode_next == MODE_WHITEN || s1_mode_next == MODE_ERR) ? din : isr_isb;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_data_reg  <= '0;
            s1_key_reg   <= '0;
            s1_mode_reg  <= MODE_WHITEN;
        end else begin
            if (accept) begin
                s1_valid_reg <= 1'b1;
                s1_data_reg  <= s1_data_next;
                s1_key_reg   <= rkey;
                s1_mode_reg  <= s1_mode_next;
            end else if (s2_load) begin
                s1_valid_reg <= 1'b0;
            end
        end
    end

    assign keyed = s1_data_reg ^ s1_key_reg;

    generate
        for (gi = 0; gi < 4; gi++) begin : g_imc
            logic [7:0] a0, a1, a2, a3;
            assign a0 = keyed[127-32*gi -: 8];
            assign a1 = keyed[119-32*gi -: 8];
            assign a2 = keyed[111-32*gi -: 8];
            assign a3 = keyed[103-32*gi -: 8];
            assign imc[127-32*gi -: 8] = mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3);
            assign imc[119-32*gi -: 8] = mul9(a0) ^ mule(a1) ^ mulb(a2) ^ muld(a3);
            assign imc[111-32*gi -: 8] = muld(a0) ^ mul9(a1) ^ mule(a2) ^ mulb(a3);
            assign imc[103-32*gi -: 8] = mulb(a0) ^ muld(a1) ^ mul9(a2) ^ mule(a3);
        end
    endgenerate

    always_comb begin
        s2_data_next = keyed;
        case (s1_mode_reg)
            MODE_MID: s2_data_next = imc;
            MODE_ERR: s2_data_next = s1_data_reg;
            default:  s2_data_next = keyed;
        endcase
    end

    // dout/round_err only change on a stage-2 load, so they stay put during a stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_valid_reg <= 1'b0;
            dout_reg       <= '0;
            round_err_reg  <= 1'b0;
        end else begin
            if (s2_load) begin
                dout_valid_reg <= 1'b1;
                dout_reg       <= s2_data_next;
                round_err_reg  <= (s1_mode_reg == MODE_ERR);
            end else if (dout_ready) begin
                dout_valid_reg <= 1'b0;
            end
        end
    end

    assign dout_valid = dout_valid_reg;
    assign dout       = dout_reg;
    assign round_err  = round_err_reg;

endmodule
